// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine plant emulator.
package wash_pkg;

    localparam int LEVEL_W = 8;
    localparam int TEMP_W  = 8;
    localparam int FAULT_W = 3;

    // Sticky fault bit positions
    localparam int F_CONFLICT = 0;  // inlet and drain open together
    localparam int F_DRYHEAT  = 1;  // heater on with an empty drum
    localparam int F_OVERFLOW = 2;  // inlet open while already full

    typedef enum logic [1:0] {
        D_STOP    = 2'd0,
        D_WASH    = 2'd1,
        D_SPIN_UP = 2'd2,
        D_SPIN    = 2'd3
    } drum_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle plant tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Terminal count decode and wrap
    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wash_plant_model.sv
// Appliance side of the wash controller interface: turns actuator commands
// into level, temperature, drum and fault state, updated once per plant tick.
module wash_plant_model
    import wash_pkg::*;
#(
    parameter int TICK_DIV      = 5_000_000,
    parameter int LEVEL_MAX     = 20,
    parameter int FILL_RATE     = 1,
    parameter int DRAIN_RATE    = 2,
    parameter int TEMP_AMBIENT  = 20,
    parameter int TEMP_TARGET   = 40,
    parameter int TEMP_MAX      = 90,
    parameter int SPIN_UP_TICKS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               water_in,
    input  logic               wash,
    input  logic               drain,
    input  logic               speed,
    input  logic               heat_r,
    input  logic               clr_fault,
    output logic               full,
    output logic               empty,
    output logic               cold,
    output logic               drum_at_speed,
    output logic [LEVEL_W-1:0] level,
    output logic [TEMP_W-1:0]  temp,
    output logic [FAULT_W-1:0] fault
);

    localparam int SCW = $clog2(SPIN_UP_TICKS + 1);

    localparam logic [LEVEL_W-1:0] LMAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W:0]   LMAXW = (LEVEL_W + 1)'(LEVEL_MAX);
    localparam logic [LEVEL_W:0]   FRATE = (LEVEL_W + 1)'(FILL_RATE);
    localparam logic [LEVEL_W-1:0] DRATE = LEVEL_W'(DRAIN_RATE);
    localparam logic [TEMP_W-1:0]  TAMB  = TEMP_W'(TEMP_AMBIENT);
    localparam logic [TEMP_W-1:0]  TTGT  = TEMP_W'(TEMP_TARGET);
    localparam logic [TEMP_W-1:0]  TMAX  = TEMP_W'(TEMP_MAX);
    localparam logic [SCW-1:0]     SPIN_LAST = SCW'(SPIN_UP_TICKS - 1);

    logic               tick;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TEMP_W-1:0]  temp_q, temp_d;
    logic [FAULT_W-1:0] fault_q, fault_d, fault_set;
    drum_e              drum_q, drum_d;
    logic [SCW-1:0]     spin_cnt_q, spin_cnt_d;
    logic               dr;
    logic [LEVEL_W:0]   lvl_sum;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Level and temperature next-state; fault set conditions use pre-update level
    always_comb begin
        level_d   = level_q;
        temp_d    = temp_q;
        fault_set = '0;
        dr        = drain | speed;
        lvl_sum   = {1'b0, level_q} + FRATE;
        if (tick) begin
            if (water_in && !dr)
                level_d = (lvl_sum > LMAXW) ? LMAX : lvl_sum[LEVEL_W-1:0];
            else if (dr && !water_in)
                level_d = (level_q > DRATE) ? level_q - DRATE : '0;
            if (water_in && dr)
                fault_set[F_CONFLICT] = 1'b1;
            if (water_in && level_q == LMAX)
                fault_set[F_OVERFLOW] = 1'b1;

            if (heat_r) begin
                if (level_q != '0) temp_d = (temp_q >= TMAX) ? TMAX : temp_q + 1'b1;
                else               fault_set[F_DRYHEAT] = 1'b1;
            end else if (temp_q > TAMB) begin
                temp_d = temp_q - 1'b1;
            end
            // Drum emptied this tick: next fill starts from fresh, ambient water
            if (level_q != '0 && level_d == '0)
                temp_d = TAMB;
        end
    end

    // Sticky faults: clear applies every edge, new sets on the same edge win
    always_comb begin
        fault_d = (clr_fault ? '0 : fault_q) | fault_set;
    end

    // Drum FSM next-state, advancing only on tick
    always_comb begin
        drum_d     = drum_q;
        spin_cnt_d = spin_cnt_q;
        if (tick) begin
            case (drum_q)
                D_STOP: begin
                    if (speed) begin
                        drum_d     = D_SPIN_UP;
                        spin_cnt_d = '0;
                    end else if (wash && level_q != '0) begin
                        drum_d = D_WASH;
                    end
                end
                D_WASH: begin
                    if (speed) begin
                        drum_d     = D_SPIN_UP;
                        spin_cnt_d = '0;
                    end else if (!wash) begin
                        drum_d = D_STOP;
                    end
                end
                D_SPIN_UP: begin
                    if (!speed)                      drum_d = D_STOP;
                    else if (spin_cnt_q == SPIN_LAST) drum_d = D_SPIN;
                    else                             spin_cnt_d = spin_cnt_q + 1'b1;
                end
                D_SPIN: begin
                    if (!speed) drum_d = D_STOP;
                end
                default: drum_d = D_STOP;
            endcase
        end
    end

    // Plant state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q    <= '0;
            temp_q     <= TAMB;
            fault_q    <= '0;
            drum_q     <= D_STOP;
            spin_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            temp_q     <= temp_d;
            fault_q    <= fault_d;
            drum_q     <= drum_d;
            spin_cnt_q <= spin_cnt_d;
        end
    end

    // Sensor decode straight from registered state
    always_comb begin
        level         = level_q;
        temp          = temp_q;
        fault         = fault_q;
        full          = (level_q == LMAX);
        empty         = (level_q == '0);
        cold          = (temp_q < TTGT);
        drum_at_speed = (drum_q == D_SPIN);
    end

endmodule

// File: tb/tb_wash_plant_model.sv
// Directed bench for the plant emulator with a small scoreboard queue and a
// behavioural wash sequence driving it closed-loop at the end.
module tb_wash_plant_model;

    logic       clk, reset;
    logic       water_in, wash, drain, speed, heat_r, clr_fault;
    logic       full, empty, cold, drum_at_speed;
    logic [7:0] level, temp;
    logic [2:0] fault;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors  = 0;
    int   miscomp  = 0;

    wash_plant_model #(
        .TICK_DIV(4), .LEVEL_MAX(8), .FILL_RATE(1), .DRAIN_RATE(2), .SPIN_UP_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .water_in(water_in), .wash(wash), .drain(drain),
        .speed(speed), .heat_r(heat_r), .clr_fault(clr_fault), .full(full),
        .empty(empty), .cold(cold), .drum_at_speed(drum_at_speed), .level(level),
        .temp(temp), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscomp++;
            $error("FAIL scoreboard_empty: observed %0d, no expected value queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                miscomp++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic ex(input string tag, input logic [31:0] v, input logic [31:0] obs);
        push(tag, v);
        chk(obs);
    endtask

    // Advance n clocks and settle just past the edge
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int  n;
        bit  ok;
        {water_in, wash, drain, speed, heat_r, clr_fault} = '0;
        reset = 1'b1;
        #12;
        ex("rst_level", 0, level);   ex("rst_temp", 20, temp);
        ex("rst_empty", 1, empty);   ex("rst_full", 0, full);
        ex("rst_cold", 1, cold);     ex("rst_das", 0, drum_at_speed);
        ex("rst_fault", 0, fault);
        @(negedge clk);
        reset = 1'b0;

        // Fill: one level unit per tick, full at tick 8
        water_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            clks(4);
            ex("fill_level", i, level);
            if (i == 1) ex("fill_not_empty", 0, empty);
            if (i == 7) ex("fill_not_full", 0, full);
        end
        ex("fill_full", 1, full);
        ex("fill_fault", 0, fault);
        water_in = 1'b0;

        // Heat: +1 per tick, cold clears at 40, saturates at 90
        heat_r = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            clks(4);
            if (k == 19) begin ex("heat_t39", 39, temp); ex("heat_cold39", 1, cold); end
            if (k == 20) begin ex("heat_t40", 40, temp); ex("heat_cold40", 0, cold); end
            if (k == 70) ex("heat_t90", 90, temp);
        end
        ex("heat_sat", 90, temp);
        ex("heat_fault", 0, fault);

        // Drain+spin: level 6,4,2,0; at speed after 4 ticks
        heat_r = 1'b0;
        speed  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            clks(4);
            ex("spin_level", 8 - 2 * i, level);
            if (i == 1) ex("spin_cool", 89, temp);
            if (i == 3) ex("spin_not_yet", 0, drum_at_speed);
        end
        ex("spin_empty", 1, empty);
        ex("spin_temp_reset", 20, temp);
        ex("spin_das", 1, drum_at_speed);
        speed = 1'b0;
        clks(4);
        ex("spin_stop", 0, drum_at_speed);

        // Misuse faults
        water_in = 1'b1;
        clks(8);
        ex("mis_level2", 2, level);
        drain = 1'b1;
        clks(4);
        ex("mis_conflict_level", 2, level);
        ex("mis_conflict", 3'b001, fault);
        water_in = 1'b0;
        clks(4);
        ex("mis_drained", 0, level);
        drain  = 1'b0;
        heat_r = 1'b1;
        clks(4);
        ex("mis_dryheat", 3'b011, fault);
        ex("mis_dryheat_temp", 20, temp);
        heat_r   = 1'b0;
        water_in = 1'b1;
        clks(32);
        ex("mis_full", 1, full);
        ex("mis_pre_ovf", 3'b011, fault);
        clks(4);
        ex("mis_overflow", 3'b111, fault);
        ex("mis_ovf_level", 8, level);
        water_in  = 1'b0;
        clr_fault = 1'b1;
        clks(1);
        ex("mis_clear", 0, fault);
        clr_fault = 1'b0;
        clks(3);
        // Clear held across a tick where overflow sets again: set wins
        water_in  = 1'b1;
        clr_fault = 1'b1;
        clks(4);
        ex("mis_set_wins", 3'b100, fault);
        water_in = 1'b0;
        clks(1);
        ex("mis_clear2", 0, fault);
        clr_fault = 1'b0;

        // Asynchronous reset during spin-up
        do_reset();
        water_in = 1'b1;
        clks(28);
        ex("rs_fill7", 7, level);
        water_in = 1'b0;
        speed    = 1'b1;
        clks(4);
        ex("rs_level5", 5, level);
        #3 reset = 1'b1;
        #1;
        ex("rs_level", 0, level);    ex("rs_temp", 20, temp);
        ex("rs_empty", 1, empty);    ex("rs_das", 0, drum_at_speed);
        speed = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Closed loop: a behavioural controller reacting to sensors each tick
        water_in = 1'b1;
        ok = 0;
        for (n = 0; n < 20 && !ok; n++) begin clks(4); ok = full; end
        ex("cl_filled", 1, ok);
        water_in = 1'b0;
        wash     = 1'b1;
        heat_r   = 1'b1;
        ok = 0;
        for (n = 0; n < 40 && !ok; n++) begin clks(4); ok = !cold; end
        ex("cl_heated", 1, ok);
        heat_r = 1'b0;
        clks(12);
        wash  = 1'b0;
        drain = 1'b1;
        ok = 0;
        for (n = 0; n < 20 && !ok; n++) begin clks(4); ok = empty; end
        ex("cl_drained", 1, ok);
        drain = 1'b0;
        speed = 1'b1;
        ok = 0;
        for (n = 0; n < 10 && !ok; n++) begin clks(4); ok = drum_at_speed; end
        ex("cl_at_speed", 1, ok);
        ex("cl_spin_ticks", 4, n);
        clks(8);
        speed = 1'b0;
        clks(4);
        ex("cl_ready_das", 0, drum_at_speed);
        ex("cl_ready_empty", 1, empty);
        ex("cl_fault", 0, fault);

        if (exp_q.size() != 0) begin
            miscomp++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
